// File: rtl/clkgate_pkg.sv
// Shared state encoding and default sizing for the multi-channel clock gater.
package clkgate_pkg;

  localparam int DEF_NCH    = 4;
  localparam int DEF_HOLD_W = 4;
  localparam int DEF_HOLD   = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/clkgate_cell.sv
// One glitch-free gate: latch transparent while the clock is low, ANDed with the clock.
module clkgate_cell (
  input  logic i_ck,
  input  logic i_en,
  input  logic i_te,
  output logic o_gck
);

  logic r_lat;

  // Closed during the high phase, so enable changes can never chop a pulse.
  always_latch begin
    if (!i_ck) r_lat <= i_en | i_te;
  end

  assign o_gck = i_ck & r_lat;

endmodule

// File: rtl/multi_clkgate.sv
// multi_clkgate: NCH independently gated copies of CK, each held open HOLD extra cycles.
// The TE test-enable port exists only when CLKGATE_TE_EN is defined.
module multi_clkgate
  import clkgate_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int HOLD   = DEF_HOLD
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [NCH-1:0]   E,
`ifdef CLKGATE_TE_EN
  input  logic             TE,
`endif
  output logic [NCH-1:0]   GCK,
  output logic [NCH-1:0]   ACK,
  output logic             ALL_IDLE,
  output logic [2*NCH-1:0] DBG_STATE
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD > 0) ? HOLD_W'(HOLD - 1) : '0;

  if (NCH < 1 || NCH > 32 || HOLD < 0 || HOLD > (2**HOLD_W) - 1) begin : g_bad_cfg
    $error("multi_clkgate: illegal NCH/HOLD/HOLD_W combination");
  end

  state_e            r_state     [NCH];
  logic [HOLD_W-1:0] r_cnt       [NCH];
  state_e            w_nxt_state [NCH];
  logic [HOLD_W-1:0] w_nxt_cnt   [NCH];
  logic [NCH-1:0]    w_nxt_off;
  logic [NCH-1:0]    r_ack;
  logic              r_idle;
  logic              w_te;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_nxt_state[i] = r_state[i];
      w_nxt_cnt[i]   = r_cnt[i];
      case (r_state[i])
        ST_OFF: begin
          if (E[i]) w_nxt_state[i] = ST_ON;
        end
        ST_ON: begin
          if (!E[i]) begin
            if (HOLD == 0) begin
              w_nxt_state[i] = ST_OFF;
            end else begin
              w_nxt_state[i] = ST_HOLD;
              w_nxt_cnt[i]   = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          // A new request re-arms straight to ON; the remaining count is discarded.
          if (E[i])                    w_nxt_state[i] = ST_ON;
          else if (r_cnt[i] == '0)     w_nxt_state[i] = ST_OFF;
          else                         w_nxt_cnt[i]   = r_cnt[i] - HOLD_W'(1);
        end
        default: w_nxt_state[i] = ST_OFF;
      endcase
      w_nxt_off[i] = (w_nxt_state[i] == ST_OFF);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
      end
      r_ack  <= '0;
      r_idle <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_nxt_state[i];
        r_cnt[i]   <= w_nxt_cnt[i];
      end
      r_ack  <= ~w_nxt_off;
      r_idle <= &w_nxt_off;
    end
  end

`ifdef CLKGATE_TE_EN
  assign w_te = TE;
`else
  assign w_te = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_cell
    clkgate_cell u_cell (
      .i_ck (CK),
      .i_en (r_ack[g]),
      .i_te (w_te),
      .o_gck(GCK[g])
    );
  end

  always_comb begin
    DBG_STATE = '0;
    for (int i = 0; i < NCH; i++) DBG_STATE[2*i +: 2] = r_state[i];
  end

  assign ACK      = r_ack;
  assign ALL_IDLE = r_idle;

endmodule

// File: tb/tb_multi_clkgate.sv
// Bench for multi_clkgate: directed table, HOLD=0 and glitch sequences, then random vs. an age model.
// Two instances: u_dut with HOLD=3 and u_dut0 with HOLD=0.
module tb_multi_clkgate;
  import clkgate_pkg::*;

  localparam int BIG = 1000;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] e = 4'hF;
  logic [3:0] e0 = 4'h0;
  logic       te = 1'b0;
  logic [3:0] gck, ack, gck0, ack0;
  logic       idle, idle0;
  logic [7:0] dbg, dbg0;

  int total = 0;
  int bad = 0;

  always #5 ck = ~ck;

  multi_clkgate #(.NCH(4), .HOLD_W(4), .HOLD(3)) u_dut (
    .CK(ck), .RST(rst), .E(e),
`ifdef CLKGATE_TE_EN
    .TE(te),
`endif
    .GCK(gck), .ACK(ack), .ALL_IDLE(idle), .DBG_STATE(dbg)
  );

  multi_clkgate #(.NCH(4), .HOLD_W(4), .HOLD(0)) u_dut0 (
    .CK(ck), .RST(rst), .E(e0),
`ifdef CLKGATE_TE_EN
    .TE(te),
`endif
    .GCK(gck0), .ACK(ack0), .ALL_IDLE(idle0), .DBG_STATE(dbg0)
  );

  // Rising-edge counters on the gated clocks; any glitch shows up as an extra count.
  int pc[4], pc0[4], pl[4], pl0[4];
  logic [3:0] gprev, gprev0;
  always @(gck) begin
    for (int i = 0; i < 4; i++) if (gck[i] === 1'b1 && gprev[i] !== 1'b1) pc[i]++;
    gprev = gck;
  end
  always @(gck0) begin
    for (int i = 0; i < 4; i++) if (gck0[i] === 1'b1 && gprev0[i] !== 1'b1) pc0[i]++;
    gprev0 = gck0;
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Pulses since the last step, per channel, saturated to 2 bits.
  task automatic chk_pul(input string nm, input logic [3:0] expg);
    logic [7:0] got, want;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = pc[i] - pl[i];
      got[2*i +: 2]  = (d > 3) ? 2'd3 : 2'(d);
      want[2*i +: 2] = {1'b0, expg[i]};
    end
    chk(nm, got, want);
  endtask

  task automatic chk_pul0(input string nm, input logic [3:0] expg);
    logic [7:0] got, want;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = pc0[i] - pl0[i];
      got[2*i +: 2]  = (d > 3) ? 2'd3 : 2'(d);
      want[2*i +: 2] = {1'b0, expg[i]};
    end
    chk(nm, got, want);
  endtask

  function automatic logic [3:0] busy(input logic [7:0] d);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (d[2*i +: 2] != ST_OFF);
    return b;
  endfunction

  // One CK cycle: inputs change at the falling edge, outputs are sampled 1ns after the rising edge.
  // gl=1 glitches E during the high phase, gl=2 during the low phase; neither may matter.
  task automatic step(input logic r, input logic [3:0] ev, input logic [3:0] ev0,
                      input logic t, input int gl);
    for (int i = 0; i < 4; i++) begin
      pl[i]  = pc[i];
      pl0[i] = pc0[i];
    end
    if (gl == 1) begin
      e = ~e; e0 = ~e0; #2;
      e = ~e; e0 = ~e0;
    end
    @(negedge ck);
    rst = r; e = ev; e0 = ev0; te = t;
    if (gl == 2) begin
      #1; e = ~ev; e0 = ~ev0;
      #2; e = ev;  e0 = ev0;
    end
    @(posedge ck);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] e;
    logic [3:0] ack;
    logic       idle;
    logic       chk_g;
    logic [3:0] gck;
  } vec_t;

  vec_t tbl[$];

  int         age[4], age0[4];
  logic [3:0] mack, mack0, expg, expg0;

  initial begin
    // reset with all requests high, single pulse on ch0, re-arm on ch1, reset mid-HOLD on ch0/ch2
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 4'h0});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 1'b0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h2, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h5, 4'h5, 1'b0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h5, 4'h5, 1'b0, 1'b1, 4'h5});
    tbl.push_back('{1'b0, 4'h0, 4'h5, 1'b0, 1'b1, 4'h5});
    tbl.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 4'h5});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0});

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].e, 4'h0, 1'b0, 0);
      chk($sformatf("tbl%0d_ack", k), {4'h0, ack}, {4'h0, tbl[k].ack});
      chk($sformatf("tbl%0d_idle", k), {7'h0, idle}, {7'h0, tbl[k].idle});
      if (tbl[k].chk_g) begin
        chk($sformatf("tbl%0d_gck", k), {4'h0, gck}, {4'h0, tbl[k].gck});
        chk_pul($sformatf("tbl%0d_pulses", k), tbl[k].gck);
      end
    end

    // HOLD=0: five requested cycles give exactly five pulses, starting one edge later
    begin
      int start2;
      start2 = pc0[2];
      for (int k = 0; k < 7; k++) begin
        logic [3:0] xa, xg;
        xa = (k < 5) ? 4'h4 : 4'h0;
        xg = (k >= 1 && k <= 5) ? 4'h4 : 4'h0;
        step(1'b0, 4'h0, (k < 5) ? 4'h4 : 4'h0, 1'b0, 0);
        chk($sformatf("h0_%0d_ack", k), {4'h0, ack0}, {4'h0, xa});
        chk($sformatf("h0_%0d_gck", k), {4'h0, gck0}, {4'h0, xg});
        chk_pul0($sformatf("h0_%0d_pulses", k), xg);
      end
      chk("h0_total", 8'(pc0[2] - start2), 8'd5);
    end

    // E glitches between sampling edges must not open anything
    for (int gl = 1; gl <= 2; gl++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, gl);
      chk($sformatf("glitch%0d_ack", gl), {ack0, ack}, 8'h00);
      chk($sformatf("glitch%0d_gck", gl), {gck0, gck}, 8'h00);
      chk_pul($sformatf("glitch%0d_pulses", gl), 4'h0);
      chk_pul0($sformatf("glitch%0d_pulses0", gl), 4'h0);
    end

`ifdef CLKGATE_TE_EN
    // TE opens every gate, even in reset, without touching the FSMs
    for (int k = 0; k < 5; k++) begin
      step((k == 3), 4'h0, 4'h0, 1'b1, (k == 2) ? 1 : 0);
      chk($sformatf("te%0d_gck", k), {gck0, gck}, 8'hFF);
      chk($sformatf("te%0d_ack", k), {ack0, ack}, 8'h00);
      chk($sformatf("te%0d_idle", k), {6'h0, idle0, idle}, 8'h03);
      chk_pul($sformatf("te%0d_pulses", k), 4'hF);
    end
    step(1'b0, 4'h0, 4'h0, 1'b0, 0);
    chk("te_off_gck", {gck0, gck}, 8'h00);
`endif

    // Random phase: a channel is open while fewer than HOLD+1 edges have passed since its last request.
    for (int i = 0; i < 4; i++) begin
      age[i] = BIG;
      age0[i] = BIG;
    end
    mack = 4'h0;
    mack0 = 4'h0;
    for (int n = 0; n < 300; n++) begin
      logic       r, t;
      logic [3:0] ev, ev0;
      r = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) begin
        ev[i]  = ($urandom_range(0, 2) == 0);
        ev0[i] = ($urandom_range(0, 2) == 0);
      end
`ifdef CLKGATE_TE_EN
      t = ($urandom_range(0, 7) == 0);
`else
      t = 1'b0;
`endif
      step(r, ev, ev0, t, int'($urandom_range(0, 3)));
      expg  = mack  | {4{te}};
      expg0 = mack0 | {4{te}};
      for (int i = 0; i < 4; i++) begin
        age[i]  = r ? BIG : (ev[i]  ? 0 : ((age[i]  >= BIG) ? BIG : age[i]  + 1));
        age0[i] = r ? BIG : (ev0[i] ? 0 : ((age0[i] >= BIG) ? BIG : age0[i] + 1));
        mack[i]  = (age[i]  <= 3);
        mack0[i] = (age0[i] <= 0);
      end
      chk($sformatf("rnd%0d_ack", n), {ack0, ack}, {mack0, mack});
      chk($sformatf("rnd%0d_idle", n), {6'h0, idle0, idle}, {6'h0, (mack0 == 4'h0), (mack == 4'h0)});
      chk($sformatf("rnd%0d_gck", n), {gck0, gck}, {expg0, expg});
      chk($sformatf("rnd%0d_state", n), {busy(dbg0), busy(dbg)}, {mack0, mack});
      chk_pul($sformatf("rnd%0d_pulses", n), expg);
      chk_pul0($sformatf("rnd%0d_pulses0", n), expg0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_clkgate.md
MULTI_CLKGATE -- requirements
Module: multi_clkgate

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of independently gated clock channels (1..32).
REQ-002 The block SHALL have parameter HOLD_W, default 4, meaning the width of the per-channel hold counter.
REQ-003 The block SHALL have parameter HOLD, default 8, meaning the extra cycles a channel stays ungated after its enable drops (0..2**HOLD_W-1).
REQ-004 The block SHALL have port CK, input, 1 bit: the single free-running source clock.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous to CK and active-high.
REQ-006 The block SHALL have port E, input, NCH bits: per-channel clock-enable request, sampled on CK rising edge.
REQ-007 The block SHALL have port TE, input, 1 bit: test enable forcing all gates open (present only under CLKGATE_TE_EN).
REQ-008 The block SHALL have port GCK, output, NCH bits: the per-channel gated clocks.
REQ-009 The block SHALL have port ACK, output, NCH bits: registered, high while the channel's gate is scheduled open.
REQ-010 The block SHALL have port ALL_IDLE, output, 1 bit: registered, high when every channel is in OFF.

Function
REQ-011 Each channel SHALL run an independent FSM with states OFF, ON and HOLD, plus a HOLD_W-bit counter cnt.
REQ-012 OFF SHALL go to ON when E[i]=1 and otherwise stay in OFF.
REQ-013 ON SHALL stay in ON when E[i]=1; when E[i]=0 it SHALL go to HOLD with cnt=HOLD-1, or go directly to OFF if HOLD=0.
REQ-014 HOLD SHALL go to ON when E[i]=1 (re-arm, cnt ignored), to OFF when E[i]=0 and cnt=0, and otherwise decrement cnt.
REQ-015 ACK[i] SHALL be 1 whenever the channel's state is not OFF; ACK SHALL be updated in the same edge as the state.
REQ-016 Each gate SHALL have a latch, transparent while CK=0, that captures ACK[i] (OR TE); GCK[i] SHALL equal CK AND the latch output, glitch-free.
REQ-017 Latency: with E[i] sampled 1 at edge n from OFF, GCK[i] SHALL pulse first at edge n+1.
REQ-018 A single-cycle E[i] pulse from OFF SHALL produce exactly HOLD+1 GCK[i] pulses.
REQ-019 Edges on E between CK rising edges SHALL have no effect; the latch SHALL never be transparent while CK=1.
REQ-020 ALL_IDLE SHALL be the registered AND of (state==OFF) over all channels, updated at the same edge as the states.
REQ-021 Channels SHALL NOT interact; simultaneous requests on any subset of channels SHALL be served in the same cycle.

Reset
REQ-022 With RST=1 at a CK rising edge, every FSM SHALL go to OFF with cnt=0, ACK=0 and ALL_IDLE=1, overriding E.
REQ-023 RST asserted during ON or HOLD SHALL close the gate: no GCK pulse from the second rising edge after RST is sampled; the edge coinciding with reset MAY still pulse.
REQ-024 After RST is released, normal operation SHALL resume on the first edge with E sampled; TE SHALL open the gates even during reset.

Configuration
REQ-025 With macro CLKGATE_TE_EN defined, the TE port SHALL exist and TE=1 SHALL open all latches within the same CK-low phase, with FSMs, ACK and ALL_IDLE unaffected.
REQ-026 Without CLKGATE_TE_EN, the TE port SHALL be absent and treated internally as 0.

Structure
REQ-027 Package clkgate_pkg SHALL hold the state enum (OFF, ON, HOLD) and the defaults for NCH, HOLD_W and HOLD.
REQ-028 Sub-module clkgate_cell SHALL contain one latch and one AND gate per channel, instantiated NCH times.
REQ-029 An elaboration check SHALL reject HOLD > 2**HOLD_W-1 and NCH < 1.

Verification
REQ-030 Reset: RST=1 for 2 cycles with E=4'b1111 -> ACK=0, ALL_IDLE=1, no GCK pulse after the second edge.
REQ-031 Single pulse: HOLD=3, E[0] high for 1 cycle -> exactly 4 GCK[0] pulses, ACK[0] high for 4 cycles, then ALL_IDLE=1.
REQ-032 Re-arm: HOLD=3, E[1] drops, then rises after 2 cycles -> GCK[1] continuous with no missing pulse, state back to ON.
REQ-033 HOLD=0: E[2] high for 5 cycles -> exactly 5 GCK[2] pulses, first at the edge after the first sampled edge.
REQ-034 Independence and reset mid-HOLD: E=4'b0101 then RST in HOLD -> channels 1 and 3 never pulse, channels 0 and 2 stop within 2 edges.
REQ-035 TE (CLKGATE_TE_EN): TE=1 with E=0 -> all GCK toggle with CK, ACK=0, ALL_IDLE=1; a glitch on E while CK=1 -> no GCK glitch.
